// File: rtl/read_dispatcher_if.sv
// Request/grant and packet-stream signals between the dispatcher, the SRAM read path and the output ports.
// The dispatcher takes the slave side; the read path and port sinks take the master side.
interface read_dispatcher_if #(
  parameter int num_of_ports       = 16,
  parameter int arbiter_data_width = 256,
  parameter int weight_width       = 4,
  parameter int port_idx_width     = 4
);
  logic                                 sp0_wrr1;
  logic [num_of_ports-1:0]              rd_req;
  logic [num_of_ports*weight_width-1:0] weight;
  logic                                 rd_start;
  logic [port_idx_width-1:0]            rd_port;
  logic                                 busy;
  logic                                 in_vld;
  logic                                 in_sop;
  logic                                 in_eop;
  logic [arbiter_data_width-1:0]        in_data;
  logic                                 in_ready;
  logic [num_of_ports-1:0]              port_ready;
  logic [num_of_ports-1:0]              out_vld;
  logic [num_of_ports-1:0]              out_sop;
  logic [num_of_ports-1:0]              out_eop;
  logic [arbiter_data_width-1:0]        out_data;

  modport master (
    output sp0_wrr1, rd_req, weight, in_vld, in_sop, in_eop, in_data, port_ready,
    input  rd_start, rd_port, busy, in_ready, out_vld, out_sop, out_eop, out_data
  );

  modport slave (
    input  sp0_wrr1, rd_req, weight, in_vld, in_sop, in_eop, in_data, port_ready,
    output rd_start, rd_port, busy, in_ready, out_vld, out_sop, out_eop, out_data
  );
endinterface

// File: rtl/read_dispatcher.sv
// Read-side port arbiter: grants one output port at a time (strict priority or WRR),
// pulses rd_start to the SRAM read path, then steers the returned packet to that port.
module read_dispatcher #(
  parameter int num_of_ports       = 16,
  parameter int arbiter_data_width = 256,
  parameter int weight_width       = 4,
  parameter int port_idx_width     = 4
) (
  input logic               clk,
  input logic               rst,
  read_dispatcher_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t                    state_reg;
  logic [port_idx_width-1:0] rd_port_reg;
  logic [port_idx_width-1:0] ptr_reg;
  logic [weight_width-1:0]   cnt_reg;
  logic                      rd_start_reg;
  logic                      busy_reg;

  logic [weight_width-1:0]   weight_arr [num_of_ports];
  logic [port_idx_width-1:0] sp_winner;
  logic [port_idx_width-1:0] wrr_winner;
  logic [port_idx_width-1:0] winner;
  logic [weight_width-1:0]   w_eff;
  logic [weight_width:0]     n_next;
  logic                      xfer;
  logic                      in_ready;
  logic                      beat;
  logic [num_of_ports-1:0]   vld_vec;
  logic [num_of_ports-1:0]   sop_vec;
  logic [num_of_ports-1:0]   eop_vec;

  assign xfer     = (state_reg == XFER);
  assign in_ready = xfer & bus.port_ready[rd_port_reg];
  assign beat     = bus.in_vld & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < num_of_ports; gi++) begin : g_port
      logic sel;
      assign weight_arr[gi] = bus.weight[gi*weight_width +: weight_width];
      assign sel            = xfer && (rd_port_reg == port_idx_width'(gi));
      assign vld_vec[gi]    = sel & bus.in_vld & bus.port_ready[gi];
      assign sop_vec[gi]    = sel & bus.in_vld & bus.port_ready[gi] & bus.in_sop;
      assign eop_vec[gi]    = sel & bus.in_vld & bus.port_ready[gi] & bus.in_eop;
    end
  endgenerate

  // Scan downwards so the lowest index (or lowest offset from ptr) is the last assignment to win.
  always_comb begin
    logic [port_idx_width-1:0] idx;
    idx        = '0;
    sp_winner  = '0;
    wrr_winner = ptr_reg;
    for (int k = num_of_ports - 1; k >= 0; k--) begin
      if (bus.rd_req[k]) sp_winner = port_idx_width'(k);
      idx = ptr_reg + port_idx_width'(k);
      if (bus.rd_req[idx]) wrr_winner = idx;
    end
  end

  assign winner = bus.sp0_wrr1 ? wrr_winner : sp_winner;
  assign w_eff  = (weight_arr[winner] == '0) ? weight_width'(1) : weight_arr[winner];
  assign n_next = ((winner == ptr_reg) ? {1'b0, cnt_reg} : '0) + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rd_port_reg  <= '0;
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      rd_start_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      rd_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|bus.rd_req) begin
            state_reg    <= START;
            rd_port_reg  <= winner;
            rd_start_reg <= 1'b1;
            busy_reg     <= 1'b1;
            if (bus.sp0_wrr1) begin
              // Port keeps the pointer until it has used up its weight in consecutive grants.
              if (n_next >= {1'b0, w_eff}) begin
                ptr_reg <= winner + 1'b1;
                cnt_reg <= '0;
              end else begin
                ptr_reg <= winner;
                cnt_reg <= n_next[weight_width-1:0];
              end
            end
          end
        end
        START: state_reg <= XFER;
        XFER: begin
          if (beat && bus.in_eop) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_start = rd_start_reg;
  assign bus.rd_port  = rd_port_reg;
  assign bus.busy     = busy_reg;
  assign bus.in_ready = in_ready;
  assign bus.out_vld  = vld_vec;
  assign bus.out_sop  = sop_vec;
  assign bus.out_eop  = eop_vec;
  assign bus.out_data = beat ? bus.in_data : '0;
endmodule

// File: tb/tb_read_dispatcher.sv
// Bench for read_dispatcher: table of packet vectors with a grant scoreboard,
// plus a hand-written mid-packet reset sequence.
module tb_read_dispatcher;
  localparam int N   = 16;
  localparam int W   = 256;
  localparam int WW  = 4;
  localparam int PIW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  read_dispatcher_if #(.num_of_ports(N), .arbiter_data_width(W),
                       .weight_width(WW), .port_idx_width(PIW)) bus ();

  read_dispatcher #(.num_of_ports(N), .arbiter_data_width(W),
                    .weight_width(WW), .port_idx_width(PIW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          mode;
    logic [N-1:0]  req;
    logic [N*WW-1:0] wts;
    int            nbeats;
    logic [3:0]    rdy;       // port_ready of the granted port, indexed by XFER cycle mod 4
    int            exp_port;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];
  int   exp_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] d;
    for (int i = 0; i < W/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic idle_inputs();
    bus.sp0_wrr1   = 1'b0;
    bus.rd_req     = '0;
    bus.weight     = '0;
    bus.in_vld     = 1'b0;
    bus.in_sop     = 1'b0;
    bus.in_eop     = 1'b0;
    bus.in_data    = '0;
    bus.port_ready = '1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Entered and left one time unit after a rising edge with the DUT in IDLE.
  task automatic run_vec(input vec_t v, input int id);
    logic [N-1:0] onehot;
    logic [W-1:0] d;
    logic         rdy;
    int           p, waited, beat, cyc;
    bus.sp0_wrr1   = v.mode;
    bus.rd_req     = v.req;
    bus.weight     = v.wts;
    bus.in_vld     = 1'b1;
    bus.in_sop     = 1'b1;
    bus.in_eop     = 1'b1;
    bus.in_data    = rand_data();
    bus.port_ready = '1;
    exp_q.push_back(v.exp_port);
    @(negedge clk);
    chk($sformatf("v%0d idle_busy", id), W'(bus.busy), '0);
    chk($sformatf("v%0d idle_in_ready", id), W'(bus.in_ready), '0);
    chk($sformatf("v%0d idle_out_vld", id), W'(bus.out_vld), '0);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.rd_start !== 1'b1 && waited < 6);
    chk($sformatf("v%0d start_latency", id), W'(waited), W'(1));
    p = exp_q.pop_front();
    if (bus.rd_start !== 1'b1) begin
      do_reset();
      return;
    end
    onehot = N'(1) << p;
    chk($sformatf("v%0d grant", id), W'(bus.rd_port), W'(p));
    chk($sformatf("v%0d start_busy", id), W'(bus.busy), W'(1));
    chk($sformatf("v%0d start_in_ready", id), W'(bus.in_ready), '0);
    chk($sformatf("v%0d start_out_vld", id), W'(bus.out_vld), '0);
    @(posedge clk);
    #1;
    // Request and mode changes mid-packet must not disturb the grant.
    bus.rd_req   = N'($urandom);
    bus.sp0_wrr1 = ~v.mode;
    beat = 0;
    cyc  = 0;
    while (beat < v.nbeats && cyc < 64) begin
      rdy               = v.rdy[cyc % 4];
      bus.port_ready    = '1;
      bus.port_ready[p] = rdy;
      bus.in_vld        = 1'b1;
      bus.in_sop        = (beat == 0);
      bus.in_eop        = (beat == v.nbeats - 1);
      d                 = rand_data();
      bus.in_data       = d;
      @(negedge clk);
      chk($sformatf("v%0d c%0d in_ready", id, cyc), W'(bus.in_ready), W'(rdy));
      chk($sformatf("v%0d c%0d out_vld", id, cyc), W'(bus.out_vld), W'(rdy ? onehot : '0));
      chk($sformatf("v%0d c%0d out_sop", id, cyc), W'(bus.out_sop),
          W'((rdy && beat == 0) ? onehot : '0));
      chk($sformatf("v%0d c%0d out_eop", id, cyc), W'(bus.out_eop),
          W'((rdy && beat == v.nbeats - 1) ? onehot : '0));
      chk($sformatf("v%0d c%0d out_data", id, cyc), bus.out_data, rdy ? d : '0);
      chk($sformatf("v%0d c%0d rd_port", id, cyc), W'(bus.rd_port), W'(p));
      @(posedge clk);
      #1;
      if (rdy) beat++;
      cyc++;
    end
    chk($sformatf("v%0d beats_done", id), W'(beat), W'(v.nbeats));
    bus.rd_req     = '0;
    bus.port_ready = '1;
    bus.in_vld     = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d eop_busy", id), W'(bus.busy), '0);
    chk($sformatf("v%0d eop_in_ready", id), W'(bus.in_ready), '0);
    chk($sformatf("v%0d eop_out_vld", id), W'(bus.out_vld), '0);
    chk($sformatf("v%0d eop_rd_start", id), W'(bus.rd_start), '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    vec_t post;
    // SP contention: ports 4 and 7 requesting, 4 wins every time.
    for (int i = 0; i < 3; i++) vecs[i] = '{1'b0, 16'h0090, '0, 3, 4'hF, 4};
    // Backpressure on port 3: ready pattern 1,0,0,1 repeating.
    vecs[3] = '{1'b0, 16'h0008, '0, 4, 4'b1001, 3};
    // WRR with weights 2/1/0 on ports 0/1/2.
    vecs[4]  = '{1'b1, 16'h0007, 64'h12, 1, 4'hF, 0};
    vecs[5]  = '{1'b1, 16'h0007, 64'h12, 1, 4'hF, 0};
    vecs[6]  = '{1'b1, 16'h0007, 64'h12, 1, 4'hF, 1};
    vecs[7]  = '{1'b1, 16'h0007, 64'h12, 1, 4'hF, 2};
    vecs[8]  = '{1'b1, 16'h0007, 64'h12, 1, 4'hF, 0};
    vecs[9]  = '{1'b1, 16'h0007, 64'h12, 1, 4'hF, 0};
    vecs[10] = '{1'b1, 16'h0007, 64'h12, 1, 4'hF, 1};
    vecs[11] = '{1'b1, 16'h0007, 64'h12, 1, 4'hF, 2};
    // Move ptr to 15, then wrap between 15 and 0.
    vecs[12] = '{1'b1, 16'h4000, 64'h1111_1111_1111_1111, 2, 4'hF, 14};
    vecs[13] = '{1'b1, 16'h8001, 64'h1111_1111_1111_1111, 1, 4'hF, 15};
    vecs[14] = '{1'b1, 16'h8001, 64'h1111_1111_1111_1111, 1, 4'hF, 0};
    vecs[15] = '{1'b1, 16'h8001, 64'h1111_1111_1111_1111, 1, 4'hF, 15};
    vecs[16] = '{1'b1, 16'h8001, 64'h1111_1111_1111_1111, 1, 4'hF, 0};

    rst = 1'b1;
    idle_inputs();
    bus.in_vld = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", W'(bus.busy), '0);
    chk("reset rd_start", W'(bus.rd_start), '0);
    chk("reset rd_port", W'(bus.rd_port), '0);
    chk("reset in_ready", W'(bus.in_ready), '0);
    chk("reset out_vld", W'(bus.out_vld), '0);
    chk("reset out_data", bus.out_data, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.in_vld = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], i);
      $display("vec %0d: mode=%0d req=%h expected port %0d", i, vecs[i].mode, vecs[i].req, vecs[i].exp_port);
    end

    // Reset in beat 2 of a 4-beat packet to port 5; ptr is 1 at this point.
    bus.sp0_wrr1 = 1'b0;
    bus.rd_req   = 16'h0020;
    exp_q.push_back(5);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_seq rd_start", W'(bus.rd_start), W'(1));
    p = exp_q.pop_front();
    chk("rst_seq grant", W'(bus.rd_port), W'(p));
    @(posedge clk);
    #1;
    bus.rd_req     = '0;
    bus.port_ready = '1;
    bus.in_vld     = 1'b1;
    bus.in_sop     = 1'b1;
    bus.in_eop     = 1'b0;
    bus.in_data    = rand_data();
    @(posedge clk);
    #1;
    bus.in_sop = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    chk("rst_seq beat2 out_vld", W'(bus.out_vld), W'(N'(1) << 5));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_seq busy", W'(bus.busy), '0);
    chk("rst_seq in_ready", W'(bus.in_ready), '0);
    chk("rst_seq out_vld", W'(bus.out_vld), '0);
    chk("rst_seq out_eop", W'(bus.out_eop), '0);
    chk("rst_seq out_data", bus.out_data, '0);
    chk("rst_seq rd_port", W'(bus.rd_port), '0);
    chk("rst_seq rd_start", W'(bus.rd_start), '0);
    $display("reset mid-packet sequence done");
    @(posedge clk);
    #1;
    // ptr back at 0 after reset: port 0 must beat port 15.
    post = '{1'b1, 16'h8001, 64'h1111_1111_1111_1111, 2, 4'hF, 0};
    run_vec(post, 99);
    $display("post-reset WRR grant, expected port 0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
